sos_input_pacer: RTL and testbench

- Upstream feeder for a cascaded biquad (SOS) section.
- Accepts Q1.15 samples on a ready/valid stream and buffers them in a small FIFO.
- Issues one sample at a time to the SOS stage as a single-cycle `data_valid_in` strobe.
- Issues the next sample only after the stage reports `data_valid_out`, or after a timeout. The SOS stage updates its w1/w2 state only on completion, so it must never see a new sample while one is in flight.

---
 rtl/sos_input_pacer.sv | 171 +++++++++++++++++
 tb/tb_sos_input_pacer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sos_input_pacer.sv
// Buffers Q1.15 samples and feeds a biquad (SOS) stage one sample at a time, waiting for its result or a timeout.
// Build option: define SOS_PACER_STATS_EN for saturating issue/timeout counters (tied to zero otherwise).
module sos_input_pacer #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_W-1:0]             s_data,
  output logic                          sos_valid_in,
  output logic [DATA_W-1:0]             sos_data_in,
  input  logic                          sos_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          timeout_pulse,
  output logic                          timeout_sticky,
  input  logic                          clr_flags,
  output logic [15:0]                   issue_count,
  output logic [15:0]                   timeout_count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_e;
  state_e state_q, state_d;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              sos_valid_q;
  logic [DATA_W-1:0] sos_data_q;
  logic              timeout_pulse_q;
  logic              sticky_q, sticky_d;
  logic              push, pop, timeout_fire;

  // Full is judged on the registered level, so a same-cycle pop never opens a slot.
  assign s_ready = (level_q != FULL_LVL);
  assign push    = s_valid && s_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (level_q != '0) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (sos_done)                    state_d = S_GAP;
        else if (wait_cnt_q == TERM_CNT) state_d = S_IDLE;
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / control decode; a result on the terminal-count cycle beats the timeout.
  always_comb begin
    pop          = 1'b0;
    timeout_fire = 1'b0;
    wait_cnt_d   = wait_cnt_q;
    case (state_q)
      S_ISSUE: begin
        pop        = 1'b1;
        wait_cnt_d = '0;
      end
      S_WAIT: begin
        wait_cnt_d   = wait_cnt_q + CNT_W'(1);
        timeout_fire = !sos_done && (wait_cnt_q == TERM_CNT);
      end
      default: ;
    endcase
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    sticky_d = sticky_q;
    if (timeout_fire)   sticky_d = 1'b1;
    else if (clr_flags) sticky_d = 1'b0;
  end

  // Sample storage has no reset so it maps onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      level_q         <= '0;
      wait_cnt_q      <= '0;
      sos_valid_q     <= 1'b0;
      sos_data_q      <= '0;
      timeout_pulse_q <= 1'b0;
      sticky_q        <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
        sos_data_q <= mem_q[rd_ptr_q];
      end
      level_q         <= level_d;
      wait_cnt_q      <= wait_cnt_d;
      sos_valid_q     <= pop;
      timeout_pulse_q <= timeout_fire;
      sticky_q        <= sticky_d;
    end
  end

  assign sos_valid_in   = sos_valid_q;
  assign sos_data_in    = sos_data_q;
  assign timeout_pulse  = timeout_pulse_q;
  assign timeout_sticky = sticky_q;
  assign fifo_level     = level_q;
  assign busy           = (state_q != S_IDLE) || (level_q != '0);

`ifdef SOS_PACER_STATS_EN
  logic [15:0] issue_cnt_q, issue_cnt_d;
  logic [15:0] to_cnt_q, to_cnt_d;

  // Counters saturate; a clear takes priority over a coincident increment.
  always_comb begin
    issue_cnt_d = issue_cnt_q;
    to_cnt_d    = to_cnt_q;
    if (clr_flags) begin
      issue_cnt_d = '0;
      to_cnt_d    = '0;
    end else begin
      if (pop && issue_cnt_q != 16'hFFFF)       issue_cnt_d = issue_cnt_q + 16'd1;
      if (timeout_fire && to_cnt_q != 16'hFFFF) to_cnt_d    = to_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt_q <= '0;
      to_cnt_q    <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign issue_count   = issue_cnt_q;
  assign timeout_count = to_cnt_q;
`else
  assign issue_count   = '0;
  assign timeout_count = '0;
`endif

endmodule

// File: tb/tb_sos_input_pacer.sv
// Directed bench for sos_input_pacer: a behavioural SOS responder plus a strobe monitor feed a single check task.
module tb_sos_input_pacer;
  localparam int DATA_W = 16;
`ifdef SOS_PACER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk, rst, s_valid, s_ready, sos_valid_in, sos_done;
  logic              busy, timeout_pulse, timeout_sticky, clr_flags;
  logic [DATA_W-1:0] s_data, sos_data_in;
  logic [3:0]        fifo_level;
  logic [15:0]       issue_count, timeout_count;

  sos_input_pacer dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .sos_valid_in(sos_valid_in), .sos_data_in(sos_data_in), .sos_done(sos_done),
    .busy(busy), .fifo_level(fifo_level), .timeout_pulse(timeout_pulse),
    .timeout_sticky(timeout_sticky), .clr_flags(clr_flags),
    .issue_count(issue_count), .timeout_count(timeout_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int resp_lat  = 0;    // 0: the stage never answers
  int resp_cnt  = 0;
  int cyc       = 0;
  int last_done = -100;
  int strobes   = 0;
  int to_pulses = 0;
  int viol      = 0;
  bit armed     = 1'b0;
  bit prev_strobe = 1'b0;
  logic [DATA_W-1:0] issued_q [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    int guard = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && guard < 400) begin
      tick();
      guard++;
    end
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
    check(tag, busy, 1'b0);
  endtask

  // SOS stage model and strobe monitor; sos_done changes on the falling edge.
  initial begin : sos_model
    sos_done = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      sos_done = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) sos_done = 1'b1;
      end
      if (sos_valid_in && resp_lat > 0) resp_cnt = resp_lat;
      if (rst) begin
        armed       = 1'b0;
        prev_strobe = 1'b0;
      end else begin
        if (sos_done && armed) begin
          armed     = 1'b0;
          last_done = cyc;
        end
        if (timeout_pulse) begin
          armed = 1'b0;
          to_pulses++;
        end
        if (sos_valid_in) begin
          if (armed || prev_strobe || (cyc - last_done) < 4) viol++;
          armed = 1'b1;
          strobes++;
          issued_q.push_back(sos_data_in);
          $display("issue #%0d data=%h t=%0t", strobes, sos_data_in, $time);
        end
        prev_strobe = sos_valid_in;
      end
    end
  end

  initial begin : main
    int sn, tp, guard, ready_bad;
    bit saw_full, busy_seen;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; clr_flags = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_level", fifo_level, 4'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_strobe", sos_valid_in, 1'b0);
    check("rst_data", sos_data_in, 16'h0000);
    check("rst_sticky", {timeout_pulse, timeout_sticky}, 2'b00);
    check("rst_counts", {issue_count, timeout_count}, 32'h0);

    // Single sample, result 10 cycles after the strobe
    resp_lat = 10;
    push(16'h1234);
    check("single_level", fifo_level, 4'd1);
    tick();
    check("single_no_early_strobe", sos_valid_in, 1'b0);
    tick();
    check("single_strobe", sos_valid_in, 1'b1);
    check("single_data", sos_data_in, 16'h1234);
    check("single_popped", fifo_level, 4'd0);
    repeat (11) tick();
    check("single_busy_in_gap", busy, 1'b1);
    tick();
    check("single_busy_fall", busy, 1'b0);
    check("single_data_held", sos_data_in, 16'h1234);
    check("single_one_strobe", strobes, 1);

    // Burst of 10 back-to-back samples
    resp_lat = 5;
    issued_q.delete();
    saw_full = 1'b0;
    ready_bad = 0;
    s_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      s_data = DATA_W'(i);
      guard = 0;
      while (!s_ready && guard < 400) begin
        if (fifo_level == 4'd8) saw_full = 1'b1;
        if (s_ready != (fifo_level != 4'd8)) ready_bad++;
        tick();
        guard++;
      end
      if (s_ready != (fifo_level != 4'd8)) ready_bad++;
      tick();
    end
    s_valid = 1'b0;
    wait_idle("burst_idle", 400);
    check("burst_saw_full", saw_full, 1'b1);
    check("burst_ready_vs_level", ready_bad, 0);
    check("burst_count", issued_q.size(), 10);
    for (int i = 0; i < issued_q.size(); i++) check("burst_order", issued_q[i], i + 1);
    check("burst_spacing", viol, 0);

    // Timeout: no answer for the first sample, the queued one follows
    resp_lat = 0;
    s_valid = 1'b1; s_data = 16'hA001;
    tick();
    s_data = 16'hA002;
    tick();
    s_valid = 1'b0;
    tick();
    check("to_first_strobe", {sos_valid_in, sos_data_in}, {1'b1, 16'hA001});
    repeat (63) tick();
    check("to_not_yet", timeout_pulse, 1'b0);
    tick();
    check("to_pulse", {timeout_pulse, timeout_sticky}, 2'b11);
    resp_lat = 3;
    tick();
    check("to_pulse_one_cycle", timeout_pulse, 1'b0);
    tick();
    check("to_next_issued", {sos_valid_in, sos_data_in}, {1'b1, 16'hA002});
    wait_idle("to_idle", 100);
    check("to_sticky_holds", timeout_sticky, 1'b1);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("to_sticky_cleared", timeout_sticky, 1'b0);

    // Result arrives exactly on the terminal-count cycle
    resp_lat = 63;
    tp = to_pulses;
    sn = strobes;
    push(16'hB00B);
    repeat (70) tick();
    wait_idle("tc_idle", 20);
    check("tc_no_pulse", to_pulses, tp);
    check("tc_sticky_clear", timeout_sticky, 1'b0);
    check("tc_issued_once", strobes, sn + 1);

    // Reset in the middle of WAIT with three samples queued
    resp_lat = 20;
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = 16'hC001 + 16'(i);
      tick();
    end
    s_valid = 1'b0;
    repeat (2) tick();
    check("mid_queued", fifo_level, 4'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_level", fifo_level, 4'd0);
    check("mid_rst_strobe", sos_valid_in, 1'b0);
    check("mid_rst_idle", busy, 1'b0);
    check("mid_rst_data", sos_data_in, 16'h0000);
    check("mid_rst_counts", {issue_count, timeout_count}, 32'h0);
    sn = strobes;
    busy_seen = 1'b0;
    repeat (30) begin
      tick();
      busy_seen |= busy;
    end
    check("mid_late_done_ignored", busy_seen, 1'b0);
    check("mid_no_strobe", strobes, sn);

    // Statistics: 2 timeouts then 3 answered issues
    resp_lat = 0;
    tp = to_pulses;
    s_valid = 1'b1; s_data = 16'hD001;
    tick();
    s_data = 16'hD002;
    tick();
    s_valid = 1'b0;
    guard = 0;
    while (to_pulses < tp + 2 && guard < 400) begin
      tick();
      guard++;
    end
    check("stats_two_timeouts", to_pulses, tp + 2);
    resp_lat = 2;
    push(16'hD003);
    push(16'hD004);
    push(16'hD005);
    wait_idle("stats_idle", 200);
    check("stats_issue_count", issue_count, STATS ? 16'd5 : 16'd0);
    check("stats_timeout_count", timeout_count, STATS ? 16'd2 : 16'd0);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("stats_cleared", {issue_count, timeout_count}, 32'h0);
    check("stats_sticky_cleared", timeout_sticky, 1'b0);
    check("overall_spacing", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
